// File: rtl/m_seq_pkg.sv
// Shared constants and helpers for the x^4+x+1 m-sequence receive checker.
package m_seq_pkg;

    // Generator polynomial: degree 4, recurrence b[n] = b[n-1] ^ b[n-4]
    localparam int POLY_DEG   = 4;
    localparam int TAP_HI     = 3;   // hist[3] holds b[n-1]
    localparam int TAP_LO     = 0;   // hist[0] holds b[n-4]
    localparam int SEQ_PERIOD = 15;  // 2^POLY_DEG - 1 non-zero states

    // Checker state encoding
    typedef logic [1:0] state_t;
    localparam state_t SEARCH = 2'd0;
    localparam state_t VERIFY = 2'd1;
    localparam state_t LOCKED = 2'd2;

    typedef logic [POLY_DEG-1:0] hist_t;

    // Next bit predicted from a 4-bit history (newest bit at the top)
    function automatic logic seq_pred(input hist_t h);
        return h[TAP_HI] ^ h[TAP_LO];
    endfunction

    // Shift a new bit in at the top of the history
    function automatic hist_t seq_shift(input hist_t h, input logic b);
        return {b, h[POLY_DEG-1:1]};
    endfunction

endpackage

// File: rtl/m_seq_checker_if.sv
// Bit-stream input and status outputs of the m-sequence checker.
interface m_seq_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             bit_in;
    logic             bit_en;
    logic             locked;
    logic             err_flag;
    logic [CNT_W-1:0] err_cnt;
    logic             win_done;

    // Bit source / status observer
    modport master (
        output bit_in, bit_en,
        input  locked, err_flag, err_cnt, win_done
    );

    // Checker side
    modport slave (
        input  bit_in, bit_en,
        output locked, err_flag, err_cnt, win_done
    );
endinterface

// File: rtl/m_seq_win_cnt.sv
// Per-window bit and error counters for the locked checker. Publishes the
// window error total in err_cnt with a win_done pulse, and flags (combinationally,
// on the closing strobe) when that total exceeds the loss-of-lock threshold.
module m_seq_win_cnt #(
    parameter int WIN_LEN = 255,
    parameter int ERR_THR = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,      // restart window (lock acquired)
    input  logic             strobe,     // one locked bit consumed
    input  logic             bit_err,    // that bit mismatched the flywheel
    output logic [CNT_W-1:0] err_cnt,
    output logic             win_done,
    output logic             over_thr    // closing strobe with total > ERR_THR
);

    localparam int               BC_W      = $clog2(WIN_LEN);
    localparam logic [BC_W-1:0]  LAST_IDX  = BC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      ERR_THR_U = ERR_THR;

    logic [BC_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0] win_err_q,  win_err_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic             win_done_q, win_done_d;

    logic [CNT_W-1:0] win_total;
    logic             win_last;

    // Saturating error total including the current bit, and end-of-window detect
    always_comb begin
        win_total = win_err_q;
        if (bit_err && (win_err_q != CNT_MAX)) begin
            win_total = win_err_q + 1'b1;
        end
        win_last = strobe && (bit_cnt_q == LAST_IDX);
        over_thr = win_last && (32'(win_total) > ERR_THR_U);
    end

    // Counter and window-result next state
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        win_err_d  = win_err_q;
        err_cnt_d  = err_cnt_q;
        win_done_d = 1'b0;
        if (clear) begin
            bit_cnt_d = '0;
            win_err_d = '0;
        end else if (strobe) begin
            if (win_last) begin
                bit_cnt_d  = '0;
                win_err_d  = '0;
                err_cnt_d  = win_total;
                win_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                win_err_d = win_total;
            end
        end
    end

    // Counter registers; err_cnt survives lock loss and is cleared only by reset
    always_ff @(posedge clk) begin
        if (srst) begin
            bit_cnt_q  <= '0;
            win_err_q  <= '0;
            err_cnt_q  <= '0;
            win_done_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            win_err_q  <= win_err_d;
            err_cnt_q  <= err_cnt_d;
            win_done_q <= win_done_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign win_done = win_done_q;

endmodule

// File: rtl/m_seq_checker.sv
// Receive-side m-sequence checker: self-synchronises on the incoming bit stream,
// then flywheels a local copy and counts bit errors per window for BER reporting.
module m_seq_checker
    import m_seq_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int WIN_LEN  = 255,
    parameter int ERR_THR  = 16,
    parameter int CNT_W    = 16
) (
    input  logic          clk_mar,
    input  logic          rst,
    m_seq_checker_if.slave sif
);

    localparam int              MC_W      = $clog2(LOCK_CNT + 1);
    localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_CNT - 1);

    state_t           state_q,    state_d;
    hist_t            hist_q,     hist_d;
    hist_t            flywheel_q, flywheel_d;
    logic [1:0]       fill_q,     fill_d;
    logic [MC_W-1:0]  match_q,    match_d;
    logic             err_flag_q, err_flag_d;
    logic             locked_q,   locked_d;

    logic             pred_rx;
    logic             pred_fw;
    logic             rx_match;
    logic             lock_hit;
    logic             win_strobe;
    logic             win_clear;
    logic             bit_err;
    logic             over_thr;
    logic [CNT_W-1:0] err_cnt;
    logic             win_done;

    // Predictions and match qualification; an all-zero history followed by a 0
    // is treated as a mismatch so a stuck-at-0 line can never lock
    always_comb begin
        pred_rx    = seq_pred(hist_q);
        pred_fw    = seq_pred(flywheel_q);
        rx_match   = (sif.bit_in == pred_rx) && !((hist_q == '0) && !sif.bit_in);
        lock_hit   = (state_q == VERIFY) && sif.bit_en && rx_match && (match_q == LOCK_LAST);
        win_strobe = sif.bit_en && (state_q == LOCKED);
        bit_err    = sif.bit_in != pred_fw;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (sif.bit_en && (fill_q == 2'd3)) state_d = VERIFY;
            VERIFY:  if (lock_hit) state_d = LOCKED;
            LOCKED:  if (over_thr) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        hist_d     = hist_q;
        flywheel_d = flywheel_q;
        fill_d     = fill_q;
        match_d    = match_q;
        err_flag_d = 1'b0;
        win_clear  = 1'b0;
        case (state_q)
            SEARCH: begin
                match_d = '0;
                if (sif.bit_en) begin
                    hist_d = seq_shift(hist_q, sif.bit_in);
                    fill_d = fill_q + 2'd1;   // wraps to 0 on the 4th bit
                end
            end
            VERIFY: begin
                if (sif.bit_en) begin
                    hist_d  = seq_shift(hist_q, sif.bit_in);
                    match_d = rx_match ? match_q + 1'b1 : '0;
                    if (lock_hit) begin
                        flywheel_d = seq_shift(hist_q, sif.bit_in);
                        match_d    = '0;
                        win_clear  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (sif.bit_en) begin
                    // Received bits are not fed back, so errors cannot propagate
                    flywheel_d = seq_shift(flywheel_q, pred_fw);
                    err_flag_d = bit_err;
                    if (over_thr) begin
                        hist_d = '0;
                        fill_d = '0;
                    end
                end
            end
            default: begin
                hist_d = '0;
                fill_d = '0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State register and registered outputs
    always_ff @(posedge clk_mar) begin
        if (rst) begin
            state_q    <= SEARCH;
            hist_q     <= '0;
            flywheel_q <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            err_flag_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            flywheel_q <= flywheel_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            err_flag_q <= err_flag_d;
            locked_q   <= locked_d;
        end
    end

    m_seq_win_cnt #(
        .WIN_LEN (WIN_LEN),
        .ERR_THR (ERR_THR),
        .CNT_W   (CNT_W)
    ) u_win_cnt (
        .clk      (clk_mar),
        .srst     (rst),
        .clear    (win_clear),
        .strobe   (win_strobe),
        .bit_err  (bit_err),
        .err_cnt  (err_cnt),
        .win_done (win_done),
        .over_thr (over_thr)
    );

    assign sif.locked   = locked_q;
    assign sif.err_flag = err_flag_q;
    assign sif.err_cnt  = err_cnt;
    assign sif.win_done = win_done;

endmodule

// File: tb/tb_m_seq_checker.sv
// Randomised bench for m_seq_checker against a phase-tracking sequence model.
module tb_m_seq_checker;

    localparam int LOCK_CNT = 8;
    localparam int WIN_LEN  = 15;
    localparam int ERR_THR  = 3;
    localparam int CNT_W    = 16;
    localparam int PERIOD   = 15;

    logic clk_mar = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_mar = ~clk_mar;

    m_seq_checker_if #(.CNT_W(CNT_W)) bus ();

    m_seq_checker #(
        .LOCK_CNT (LOCK_CNT),
        .WIN_LEN  (WIN_LEN),
        .ERR_THR  (ERR_THR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_mar (clk_mar),
        .rst     (rst),
        .sif     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // One full period of the sequence, generated from the recurrence
    bit seq [PERIOD];
    int g_phase;

    // Reference model: mode 0 = searching, 1 = verifying, 2 = locked
    int m_mode;
    bit m_rx [$];
    int m_matches;
    int m_phase;
    int m_nbits;
    int m_winerr;
    int m_errcnt;
    bit m_locked;
    int strobe_no;
    int lock_rise_at;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (strobe %0d)", tag, obs, exp, strobe_no);
        end
    endtask

    function automatic bit gen_next();
        bit b;
        b = seq[g_phase];
        g_phase = (g_phase + 1) % PERIOD;
        return b;
    endfunction

    // Position in the period following the last four received bits
    function automatic int find_phase();
        int n;
        n = m_rx.size();
        for (int i = 0; i < PERIOD; i++) begin
            if (seq[i] == m_rx[n-4] && seq[(i+1)%PERIOD] == m_rx[n-3] &&
                seq[(i+2)%PERIOD] == m_rx[n-2] && seq[(i+3)%PERIOD] == m_rx[n-1])
                return (i + 4) % PERIOD;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_rx.delete();
        m_matches = 0;
        m_nbits   = 0;
        m_winerr  = 0;
        m_errcnt  = 0;
        m_locked  = 0;
    endtask

    task automatic model_step(input bit b, output bit e_flag, output bit e_done);
        int n;
        bit ok, allz, exp_b;
        e_flag = 0;
        e_done = 0;
        case (m_mode)
            0: begin
                m_rx.push_back(b);
                if (m_rx.size() == 4) begin
                    m_mode    = 1;
                    m_matches = 0;
                end
            end
            1: begin
                n    = m_rx.size();
                allz = !(m_rx[n-1] | m_rx[n-2] | m_rx[n-3] | m_rx[n-4]);
                ok   = (b == (m_rx[n-1] ^ m_rx[n-4])) && !(allz && !b);
                m_rx.push_back(b);
                if (m_rx.size() > 8) void'(m_rx.pop_front());
                m_matches = ok ? m_matches + 1 : 0;
                if (m_matches == LOCK_CNT) begin
                    m_mode   = 2;
                    m_locked = 1;
                    m_phase  = find_phase();
                    m_nbits  = 0;
                    m_winerr = 0;
                end
            end
            default: begin
                exp_b   = seq[m_phase];
                m_phase = (m_phase + 1) % PERIOD;
                e_flag  = (b != exp_b);
                if (e_flag) m_winerr++;
                m_nbits++;
                if (m_nbits == WIN_LEN) begin
                    m_errcnt = m_winerr;
                    e_done   = 1;
                    if (m_winerr > ERR_THR) begin
                        m_mode   = 0;
                        m_locked = 0;
                        m_rx.delete();
                    end
                    m_nbits  = 0;
                    m_winerr = 0;
                end
            end
        endcase
    endtask

    task automatic check_idle();
        check_eq("gap_err_flag", bus.err_flag, 0);
        check_eq("gap_win_done", bus.win_done, 0);
        check_eq("gap_locked",   bus.locked, m_locked);
        check_eq("gap_err_cnt",  bus.err_cnt, m_errcnt);
    endtask

    task automatic send_bit(input bit b, input int gap);
        bit ef, ed, prev_locked;
        bus.bit_in = b;
        bus.bit_en = 1'b1;
        @(posedge clk_mar);
        #1;
        bus.bit_en = 1'b0;
        bus.bit_in = 1'($urandom);
        strobe_no++;
        prev_locked = m_locked;
        model_step(b, ef, ed);
        if (!prev_locked && m_locked) lock_rise_at = strobe_no;
        $display("[TB] strobe %0d bit=%0b locked=%0b err_flag=%0b win_done=%0b err_cnt=%0d",
                 strobe_no, b, bus.locked, bus.err_flag, bus.win_done, bus.err_cnt);
        check_eq("err_flag", bus.err_flag, ef);
        check_eq("win_done", bus.win_done, ed);
        check_eq("locked",   bus.locked, m_locked);
        check_eq("err_cnt",  bus.err_cnt, m_errcnt);
        repeat (gap) begin
            @(posedge clk_mar);
            #1;
            check_idle();
        end
    endtask

    task automatic send_gen(input int n, input int flip_lo, input int flip_hi, input int max_gap);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = gen_next();
            if (i >= flip_lo && i <= flip_hi) b = ~b;
            send_bit(b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    // Reset with a strobe asserted; that strobe must be ignored
    task automatic do_reset();
        rst        = 1'b1;
        bus.bit_en = 1'b1;
        bus.bit_in = 1'($urandom);
        repeat (2) @(posedge clk_mar);
        #1;
        rst          = 1'b0;
        bus.bit_en   = 1'b0;
        model_reset();
        strobe_no    = 0;
        lock_rise_at = -1;
        $display("[TB] reset");
        check_eq("rst_locked",   bus.locked, 0);
        check_eq("rst_err_cnt",  bus.err_cnt, 0);
        check_eq("rst_err_flag", bus.err_flag, 0);
        check_eq("rst_win_done", bus.win_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        bit b;

        seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b0; seq[3] = 1'b0;
        for (int i = 4; i < PERIOD; i++) seq[i] = seq[i-1] ^ seq[i-4];
        g_phase      = $urandom_range(0, PERIOD - 1);
        bus.bit_en   = 1'b0;
        bus.bit_in   = 1'b0;
        strobe_no    = 0;
        lock_rise_at = -1;
        model_reset();

        // Clean stream, continuous strobes: lock on the 12th strobe
        do_reset();
        send_gen(57, -1, -1, 0);
        check_eq("lock_at_12", lock_rise_at, 12);

        // Single bit error inside a window, with strobe gaps
        send_gen(30, 7, 7, 5);
        check_eq("single_err_locked", bus.locked, 1);

        // Four errors in one window: drop at window end, relock 12 strobes later
        do_reset();
        send_gen(20, -1, -1, 0);
        lock_rise_at = -1;
        send_gen(25, 2, 5, 0);
        check_eq("relock_at_39", lock_rise_at, 39);
        check_eq("drop_err_cnt", bus.err_cnt, 4);

        // Error on the bit that would have completed the lock
        do_reset();
        send_gen(40, 11, 11, 3);
        check_eq("verify_flip_lock_at", lock_rise_at, 24);

        // Stuck-at-0 line never locks
        do_reset();
        for (int i = 0; i < 100; i++) send_bit(1'b0, $urandom_range(0, 5));
        check_eq("zeros_locked", bus.locked, 0);

        // Reset while locked mid-window, then relock
        do_reset();
        send_gen(35, 15, 15, 0);
        check_eq("pre_rst_err_cnt", bus.err_cnt, 1);
        do_reset();
        send_gen(12, -1, -1, 2);
        check_eq("post_rst_lock_at", lock_rise_at, 12);

        // Long random run: sparse errors plus occasional error bursts
        do_reset();
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            b = gen_next();
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(4, 20);
            if (burst > 0) begin
                burst--;
                if ($urandom_range(0, 1) == 0) b = ~b;
            end else if ($urandom_range(0, 29) == 0) begin
                b = ~b;
            end
            send_bit(b, $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
